// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_count;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_idle_start;
  logic        w_accept;
  logic        w_commit;
  logic        w_dsigned;
  logic [31:0] w_da;
  logic [31:0] w_db;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [63:0] w_res;

  // Decode which opcodes occupy the unit for multiple cycles
  always_comb begin
    w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
    w_is_mul = w_is_mul || (MDUOp == OP_MADD) || (MDUOp == OP_MADDU) ||
               (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
`endif
    w_is_div     = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    w_idle_start = Start && (r_state == S_IDLE);
    w_accept     = w_idle_start && (w_is_mul || w_is_div);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: leave RUN on the edge the count goes 1 -> 0
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (r_count == 5'd1) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs of the FSM: Busy for the whole RUN, commit on its last cycle
  always_comb begin
    Busy     = (r_state == S_RUN);
    w_commit = (r_state == S_RUN) && (r_count == 5'd1);
  end

  // Latency counter and latched operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 5'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
    end else if (w_accept) begin
      r_count <= w_is_div ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);
      r_op    <= MDUOp;
      r_a     <= Data1;
      r_b     <= Data2;
    end else if (r_state == S_RUN) begin
      r_count <= r_count - 5'd1;
    end
  end

  // Arithmetic on the latched operands; division works on magnitudes then restores signs
  always_comb begin
    w_sprod   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    w_uprod   = {32'd0, r_a} * {32'd0, r_b};
    w_dsigned = (r_op == OP_DIV);
    w_da      = (w_dsigned && r_a[31]) ? (~r_a + 32'd1) : r_a;
    w_db      = (w_dsigned && r_b[31]) ? (~r_b + 32'd1) : r_b;
    w_uq      = w_da / w_db;
    w_ur      = w_da % w_db;
    w_q       = (w_dsigned && (r_a[31] ^ r_b[31])) ? (~w_uq + 32'd1) : w_uq;
    w_r       = (w_dsigned && r_a[31]) ? (~w_ur + 32'd1) : w_ur;
    w_res     = {r_hi, r_lo};
    case (r_op)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_DIV, OP_DIVU: begin
        if (r_b == 32'd0) w_res = {r_a, 32'hFFFF_FFFF};
        else              w_res = {w_r, w_q};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  w_res = {r_hi, r_lo} + w_sprod;
      OP_MADDU: w_res = {r_hi, r_lo} + w_uprod;
      OP_MSUB:  w_res = {r_hi, r_lo} - w_sprod;
      OP_MSUBU: w_res = {r_hi, r_lo} - w_uprod;
`endif
      default:  w_res = {r_hi, r_lo};
    endcase
  end

  // HI/LO: committed at end of RUN, or written directly by MTHI/MTLO while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_res[63:32];
      r_lo <= w_res[31:0];
    end else if (w_idle_start && (MDUOp == OP_MTHI)) begin
      r_hi <= Data1;
    end else if (w_idle_start && (MDUOp == OP_MTLO)) begin
      r_lo <= Data1;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard testbench for mdu with a plain-arithmetic HI/LO reference model
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] Data1 = 32'd0;
  logic [31:0] Data2 = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDUOp(MDUOp),
    .Data1(Data1), .Data2(Data2), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic [3:0]  op;
  } exp_t;

  exp_t        scb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what HI/LO become after op, and how long the unit is busy (0 = not a long op)
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi_in, input logic [31:0] lo_in,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    int          sa = a;
    int          sbv = b;
    logic [63:0] sp = longint'(sa) * longint'(sbv);
    logic [63:0] up = {32'd0, a} * {32'd0, b};
    logic [63:0] acc = {hi_in, lo_in};
    hi  = hi_in;
    lo  = lo_in;
    lat = 0;
    case (op)
      4'd1: begin {hi, lo} = sp; lat = 5; end
      4'd2: begin {hi, lo} = up; lat = 5; end
      4'd3: begin
        lat = 10;
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin lo = sa / sbv; hi = sa % sbv; end
      end
      4'd4: begin
        lat = 10;
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      4'd5: hi = a;
      4'd6: lo = a;
`ifdef MDU_MADD_EN
      4'd7:  begin {hi, lo} = acc + sp; lat = 5; end
      4'd8:  begin {hi, lo} = acc + up; lat = 5; end
      4'd9:  begin {hi, lo} = acc - sp; lat = 5; end
      4'd10: begin {hi, lo} = acc - up; lat = 5; end
`endif
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    Start = 1'b1; MDUOp = op; Data1 = a; Data2 = b;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Busy && n < 100);
    n_cmp++;
    if (Busy) begin
      n_err++;
      $display("FAIL wait_idle: Busy still 1 after 100 cycles, expected 0");
    end
  endtask

  // Predict a long op (push to scoreboard) or check a short op right away
  task automatic push_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    int          lat;
    exp_t        e;
    model(op, a, b, m_hi, m_lo, h, l, lat);
    e.hi = h; e.lo = l; e.lat = lat; e.op = op;
    scb.push_back(e);
    m_hi = h; m_lo = l;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    int          lat;
    model(op, a, b, m_hi, m_lo, h, l, lat);
    if (lat > 0) begin
      push_long(op, a, b);
      issue(op, a, b);
      wait_idle();
    end else begin
      issue(op, a, b);
      m_hi = h; m_lo = l;
      chk("short_op_busy", {31'd0, Busy}, 32'd0);
      chk("short_op_hi", HI, m_hi);
      chk("short_op_lo", LO, m_lo);
    end
  endtask

  // Monitor: on each Busy fall, pop the prediction and compare HI/LO and busy length
  int   bcnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_busy = 1'b0;
      bcnt = 0;
    end else if (Busy) begin
      bcnt++;
      prev_busy = 1'b1;
    end else if (prev_busy) begin
      prev_busy = 1'b0;
      if (scb.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = scb.pop_front();
        chk("busy_len", 32'(bcnt), 32'(e.lat));
        chk("commit_hi", HI, e.hi);
        chk("commit_lo", LO, e.lo);
      end
      bcnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          sel;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset in the middle of a MULT discards it
    do_op(4'd5, 32'hAAAA_5555, 32'd0);
    do_op(4'd6, 32'h1357_9BDF, 32'd0);
    issue(4'd1, 32'h0001_0000, 32'h0001_0000);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, Busy}, 32'd0);
    chk("midrun_reset_hi", HI, 32'd0);
    chk("midrun_reset_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); #1 reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_busy", {31'd0, Busy}, 32'd0);
    chk("post_reset_hi", HI, 32'd0);
    chk("post_reset_lo", LO, 32'd0);

    // Directed vectors
    do_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    do_op(4'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    do_op(4'd4, 32'd100, 32'd0);
    chk("divu0_lo", LO, 32'hFFFF_FFFF);
    chk("divu0_hi", HI, 32'd100);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    // MTHI while Busy is ignored; HI holds its pre-op value during RUN
    do_op(4'd5, 32'hCAFE_0000, 32'd0);
    push_long(4'd1, 32'd3, 32'd4);
    issue(4'd1, 32'd3, 32'd4);
    issue(4'd5, 32'h0000_1234, 32'd0);
    chk("busy_mthi_ignored", HI, 32'hCAFE_0000);
    wait_idle();
    chk("after_busy_mthi_hi", HI, 32'd0);

    // Start on the commit edge is ignored; Start the cycle after is accepted
    push_long(4'd4, 32'd1000, 32'd7);
    issue(4'd4, 32'd1000, 32'd7);
    repeat (8) @(posedge clk);
    issue(4'd6, 32'h0000_0055, 32'd0);
    chk("commit_edge_busy", {31'd0, Busy}, 32'd0);
    chk("commit_edge_lo", LO, 32'd142);
    push_long(4'd2, 32'd6, 32'd7);
    Start = 1'b1; MDUOp = 4'd2; Data1 = 32'd6; Data2 = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    chk("restart_busy", {31'd0, Busy}, 32'd1);
    wait_idle();

    // MTLO in IDLE
    do_op(4'd6, 32'h0000_0055, 32'd0);
    chk("mtlo_lo", LO, 32'h0000_0055);

    // MADDU accumulate (or no effect when the feature is absent)
    do_op(4'd5, 32'd0, 32'd0);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd0);
    do_op(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
`else
    chk("maddu_off_hi", HI, 32'd0);
    chk("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

    // Randomized operations, with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 50) - 25; b = $urandom_range(1, 9); end
      do_op(op, a, b);
      chk("rand_hi", HI, m_hi);
      chk("rand_lo", LO, m_lo);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
